// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor: one SEG-bit carry segment per stage,
// valid/ready handshake with a global advance so the whole pipe stalls or shifts together.
module pipelined_addsub #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int STAGES = WIDTH / SEG;
  localparam int LAST   = STAGES - 1;

  logic                         advance;
  logic                         accept;
  logic                         flag_ld;
  logic [WIDTH-1:0]             yb_in;
  logic                         c0;
  logic [SEG:0]                 sum;
  logic [STAGES-1:0]            vld;
  logic [STAGES-1:0]            cq;
  logic [STAGES-1:0]            cn;
  logic [STAGES-1:0][WIDTH-1:0] xq;
  logic [STAGES-1:0][WIDTH-1:0] yq;
  logic [STAGES-1:0][WIDTH-1:0] rq;
  logic [STAGES-1:0][WIDTH-1:0] xn;
  logic [STAGES-1:0][WIDTH-1:0] yn;
  logic [STAGES-1:0][WIDTH-1:0] rn;
  logic                         ovf_n;
  logic                         zero_n;
  logic                         ovf_q;
  logic                         zero_q;

  assign advance = ~out_valid | out_ready;
  assign in_ready = advance;
  assign accept = in_valid & advance;
  assign yb_in = y ^ {WIDTH{sub}};
  assign c0 = cin ^ sub;
  // A single-stage pipe only loads its flags on a real accept, like its data.
  assign flag_ld = (LAST == 0) ? accept : advance;

  // Stage k resolves segment k from the carry of stage k-1; operands ride along unchanged
  // (skew) and finished lower segments ride along in the result word (deskew).
  always_comb begin
    xn = '0;
    yn = '0;
    rn = '0;
    cn = '0;
    sum = {1'b0, x[SEG-1:0]} + {1'b0, yb_in[SEG-1:0]} + {{SEG{1'b0}}, c0};
    xn[0] = x;
    yn[0] = yb_in;
    rn[0][SEG-1:0] = sum[SEG-1:0];
    cn[0] = sum[SEG];
    for (int k = 1; k < STAGES; k++) begin
      sum = {1'b0, xq[k-1][k*SEG +: SEG]} + {1'b0, yq[k-1][k*SEG +: SEG]}
            + {{SEG{1'b0}}, cq[k-1]};
      xn[k] = xq[k-1];
      yn[k] = yq[k-1];
      rn[k] = rq[k-1];
      rn[k][k*SEG +: SEG] = sum[SEG-1:0];
      cn[k] = sum[SEG];
    end
    ovf_n = (xn[LAST][WIDTH-1] == yn[LAST][WIDTH-1]) &&
            (rn[LAST][WIDTH-1] != xn[LAST][WIDTH-1]);
    zero_n = ~|rn[LAST];
  end

  // Stage 0 captures operands only on accept; bubbles shift through as valid=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld    <= '0;
      cq     <= '0;
      xq     <= '0;
      yq     <= '0;
      rq     <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      if (accept) begin
        xq[0] <= xn[0];
        yq[0] <= yn[0];
        rq[0] <= rn[0];
        cq[0] <= cn[0];
      end
      if (advance) begin
        vld[0] <= accept;
        for (int k = 1; k < STAGES; k++) begin
          vld[k] <= vld[k-1];
          xq[k]  <= xn[k];
          yq[k]  <= yn[k];
          rq[k]  <= rn[k];
          cq[k]  <= cn[k];
        end
      end
      if (flag_ld) begin
        ovf_q  <= ovf_n;
        zero_q <= zero_n;
      end
    end
  end

  assign out_valid = vld[LAST];
  assign s         = rq[LAST];
  assign cout      = cq[LAST];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub: W16/S4 vectors, backpressure and async reset,
// plus W8/S8 and W8/S2 streams against a behavioural model with random out_ready.
module tb_pipelined_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b1;

  logic        iv16, ir16, cin16, sub16, ov16, or16, co16, ovf16, z16;
  logic [15:0] x16, y16, s16;

  logic       iv8[2], ir8[2], cin8[2], sub8[2], ov8[2], or8[2], co8[2], ovf8[2], z8[2];
  logic [7:0] x8[2], y8[2], s8[2];

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [15:0] a, b;
    logic        ci, sb;
    logic [15:0] es;
    logic        ec, eo, ez;
  } vec_t;

  pipelined_addsub #(.WIDTH(16), .SEG(4)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .x(x16), .y(y16),
    .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(or16), .s(s16),
    .cout(co16), .ovf(ovf16), .zero(z16));

  pipelined_addsub #(.WIDTH(8), .SEG(8)) u8a (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8[0]), .in_ready(ir8[0]), .x(x8[0]), .y(y8[0]),
    .cin(cin8[0]), .sub(sub8[0]), .out_valid(ov8[0]), .out_ready(or8[0]), .s(s8[0]),
    .cout(co8[0]), .ovf(ovf8[0]), .zero(z8[0]));

  pipelined_addsub #(.WIDTH(8), .SEG(2)) u8b (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8[1]), .in_ready(ir8[1]), .x(x8[1]), .y(y8[1]),
    .cin(cin8[1]), .sub(sub8[1]), .out_valid(ov8[1]), .out_ready(or8[1]), .s(s8[1]),
    .cout(co8[1]), .ovf(ovf8[1]), .zero(z8[1]));

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sends one W16 beat into an empty pipe and counts edges (accept edge = 1) until out_valid.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input logic ci, input logic sb, output int lat);
    @(negedge clk);
    x16 = a; y16 = b; cin16 = ci; sub16 = sb; iv16 = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    iv16 = 1'b0;
    while (!ov16 && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  function automatic logic [10:0] model8(input logic [7:0] a, input logic [7:0] b,
                                         input logic ci, input logic sb);
    logic [7:0] yb;
    logic [8:0] t;
    logic       ov;
    yb = b ^ {8{sb}};
    t  = {1'b0, a} + {1'b0, yb} + {8'd0, ci ^ sb};
    ov = (a[7] == yb[7]) && (t[7] != a[7]);
    return {t[8], ov, (t[7:0] == 8'd0), t[7:0]};
  endfunction

  task automatic runStream8(input int inst, input int nb);
    logic [10:0] expq[$];
    logic [10:0] e;
    logic [9:0]  i;
    int sent, popped, cyc;
    sent = 0; popped = 0; cyc = 0;
    while (popped < nb && cyc < 10000) begin
      @(negedge clk);
      i = 10'(sent);
      x8[inst]   = i[7:0];
      y8[inst]   = 8'(sent * 73 + 5);
      cin8[inst] = i[8];
      sub8[inst] = i[9];
      iv8[inst]  = (sent < nb) && ($urandom_range(0, 4) != 0);
      or8[inst]  = ($urandom_range(0, 3) != 0);
      #1;
      if (ov8[inst] && or8[inst]) begin
        checkOutput($sformatf("t6_inst%0d_nonempty", inst), 32'(expq.size() != 0), 32'd1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          checkOutput($sformatf("t6_inst%0d_beat%0d", inst, popped),
                      {21'd0, co8[inst], ovf8[inst], z8[inst], s8[inst]}, {21'd0, e});
        end
        popped++;
      end
      if (iv8[inst] && ir8[inst]) begin
        expq.push_back(model8(x8[inst], y8[inst], cin8[inst], sub8[inst]));
        sent++;
      end
      cyc++;
    end
    iv8[inst] = 1'b0;
    or8[inst] = 1'b1;
    checkOutput($sformatf("t6_inst%0d_count", inst), popped, nb);
  endtask

  initial begin
    vec_t        vecs[8];
    logic [15:0] t4exp[8];
    int          lat, sent, popped, cyc, irBad, holdBad, stalls, cnt;
    logic        holding;
    logic [15:0] held;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    t4exp = '{16'h1212, 16'h2323, 16'h3434, 16'h4545, 16'h5656, 16'h6767, 16'h7878, 16'h8989};

    iv16 = 1'b0; or16 = 1'b1; x16 = '0; y16 = '0; cin16 = 1'b0; sub16 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      iv8[k] = 1'b0; or8[k] = 1'b1; x8[k] = '0; y8[k] = '0; cin8[k] = 1'b0; sub8[k] = 1'b0;
    end

    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_out_valid", ov16, 0);
    checkOutput("reset_s", s16, 0);
    checkOutput("reset_flags", {co16, ovf16, z16}, 0);
    checkOutput("reset_in_ready", ir16, 1);
    checkOutput("reset_w8_out_valid", {ov8[0], ov8[1]}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // T1-T3: directed single beats, latency of 4 edges each
    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].a, vecs[v].b, vecs[v].ci, vecs[v].sb, lat);
      checkOutput($sformatf("vec%0d_latency", v), lat, 4);
      checkOutput($sformatf("vec%0d_s", v), s16, vecs[v].es);
      checkOutput($sformatf("vec%0d_cout_ovf_zero", v), {co16, ovf16, z16},
                  {vecs[v].ec, vecs[v].eo, vecs[v].ez});
    end

    // T4: 8 back-to-back beats, out_ready low for 3 cycles mid-stream
    sent = 0; popped = 0; cyc = 0; irBad = 0; holdBad = 0; stalls = 0;
    holding = 1'b0; held = '0;
    while (popped < 8 && cyc < 60) begin
      @(negedge clk);
      or16  = !(cyc >= 6 && cyc < 9);
      iv16  = (sent < 8);
      x16   = 16'h1111 * 16'(sent + 1);
      y16   = 16'h0101;
      cin16 = 1'b0;
      sub16 = 1'b0;
      #1;
      if (holding && (s16 !== held || !ov16)) holdBad++;
      if (ir16 !== !(ov16 && !or16)) irBad++;
      if (ov16 && !or16) stalls++;
      if (ov16 && or16) begin
        checkOutput($sformatf("t4_beat%0d", popped), s16, t4exp[popped]);
        popped++;
      end
      holding = ov16 && !or16;
      held = s16;
      if (iv16 && ir16) sent++;
      cyc++;
    end
    iv16 = 1'b0;
    or16 = 1'b1;
    checkOutput("t4_count", popped, 8);
    checkOutput("t4_stall_cycles", stalls, 3);
    checkOutput("t4_in_ready_rule", irBad, 0);
    checkOutput("t4_hold_stable", holdBad, 0);

    // T5: fill the pipe with 3 beats, hold the head, then reset mid-cycle
    @(negedge clk);
    or16 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      x16 = 16'hFFFF; y16 = 16'(i + 2); cin16 = 1'b0; sub16 = 1'b0; iv16 = 1'b1;
      @(negedge clk);
    end
    iv16 = 1'b0;
    cnt = 0;
    while (!ov16 && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("t5_prefill_valid", ov16, 1);
    checkOutput("t5_prefill_s", {co16, s16}, {1'b1, 16'h0001});
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5_async_out_valid", ov16, 0);
    checkOutput("t5_async_s", s16, 0);
    checkOutput("t5_async_flags", {co16, ovf16, z16}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    or16 = 1'b1;
    applyStimulus(16'h0003, 16'h0004, 1'b0, 1'b0, lat);
    checkOutput("t5_post_latency", lat, 4);
    checkOutput("t5_post_s", s16, 16'h0007);

    // T6: W8/S8 and W8/S2 streams across every x with all cin/sub combinations
    runStream8(0, 1024);
    runStream8(1, 1024);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
